// File: rtl/fairy_exu_pkg.sv
// rtl/fairy_exu_pkg.sv - op/state types and op-class helpers for fairy_exe_unit (divider gated by FAIRY_EXU_DIV_EN)
package fairy_exu_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUB   = 5'd2,
    OP_SUBU  = 5'd3,
    OP_SLT   = 5'd4,
    OP_SLTU  = 5'd5,
    OP_AND   = 5'd6,
    OP_OR    = 5'd7,
    OP_XOR   = 5'd8,
    OP_NOR   = 5'd9,
    OP_SLL   = 5'd10,
    OP_SRL   = 5'd11,
    OP_SRA   = 5'd12,
    OP_LUI   = 5'd13,
    OP_MFHI  = 5'd14,
    OP_MFLO  = 5'd15,
    OP_MTHI  = 5'd16,
    OP_MTLO  = 5'd17,
    OP_MULT  = 5'd18,
    OP_MULTU = 5'd19,
    OP_DIV   = 5'd20,
    OP_DIVU  = 5'd21
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

`ifdef FAIRY_EXU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  function automatic logic op_is_mul(op_e op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // Divides only count as multi-cycle work when the divider is built in
  function automatic logic op_is_div(op_e op);
    return DIV_EN && ((op == OP_DIV) || (op == OP_DIVU));
  endfunction

  function automatic logic op_is_signed_md(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/fairy_exu_mdu.sv
// rtl/fairy_exu_mdu.sv - iterative shift-add multiplier / restoring divider (divider built only with FAIRY_EXU_DIV_EN)
module fairy_exu_mdu
  import fairy_exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            abort_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int CNT_W = $clog2(XLEN);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   acc_q, q_q, m_q;
  logic              pneg_q, rneg_q, div_q;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod;

  // Work on magnitudes; signs are re-applied in FIX
  assign a_mag   = (signed_i && a_i[XLEN-1]) ? -a_i : a_i;
  assign b_mag   = (signed_i && b_i[XLEN-1]) ? -b_i : b_i;
  assign mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);

`ifdef FAIRY_EXU_DIV_EN
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic            div_borrow;
  assign div_shift  = {acc_q, q_q[XLEN-1]};
  assign div_diff   = {1'b0, div_shift} - {2'b00, m_q};
  assign div_borrow = div_diff[XLEN+1];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: XLEN iterations then one FIX cycle; abort always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = (is_div_i && DIV_EN) ? ST_DIV : ST_MUL;
      ST_MUL, ST_DIV: if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) state_d = ST_IDLE;
  end

  // Status outputs
  always_comb begin
    busy_o = (state_q != ST_IDLE);
    done_o = (state_q == ST_FIX);
  end

  // Datapath: operand load on start, one multiply or divide step per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      q_q    <= '0;
      m_q    <= '0;
      pneg_q <= 1'b0;
      rneg_q <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          cnt_q  <= CNT_W'(XLEN - 1);
          acc_q  <= '0;
          q_q    <= a_mag;
          m_q    <= b_mag;
          pneg_q <= signed_i & (a_i[XLEN-1] ^ b_i[XLEN-1]);
          rneg_q <= signed_i & a_i[XLEN-1];
          div_q  <= is_div_i & DIV_EN;
        end
        ST_MUL: begin
          acc_q <= mul_sum[XLEN:1];
          q_q   <= {mul_sum[0], q_q[XLEN-1:1]};
          cnt_q <= cnt_q - 1'b1;
        end
`ifdef FAIRY_EXU_DIV_EN
        ST_DIV: begin
          acc_q <= div_borrow ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
          q_q   <= {q_q[XLEN-2:0], ~div_borrow};
          cnt_q <= cnt_q - 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Sign correction of the finished magnitudes
  always_comb begin
    prod = {acc_q, q_q};
    if (pneg_q) prod = -prod;
    hi_o = prod[2*XLEN-1:XLEN];
    lo_o = prod[XLEN-1:0];
    if (div_q) begin
      hi_o = rneg_q ? -acc_q : acc_q;
      lo_o = pneg_q ? -q_q : q_q;
    end
  end

endmodule

// File: rtl/fairy_exe_unit.sv
// rtl/fairy_exe_unit.sv - single-entry integer execute unit with HI/LO and iterative MDU (divider via FAIRY_EXU_DIV_EN)
module fairy_exe_unit
  import fairy_exu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  op_e                op_i,
  input  logic [XLEN-1:0]    a_i,
  input  logic [XLEN-1:0]    b_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [4:0]         waddr_i,
  input  logic               we_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [XLEN-1:0]    data_o,
  output logic [XLEN-1:0]    pc_o,
  output logic [4:0]         waddr_o,
  output logic               we_o,
  output logic               overflow_o,
  output logic               illegal_o,
  output logic               busy_o
);

  logic            accept, is_md, md_busy, md_done;
  logic [XLEN-1:0] md_hi, md_lo, sum, diff, res;
  logic            add_ovf, sub_ovf, ovf, ill, wr;
  logic            ov_q, ov_d, we_q, we_d, ovf_q, ovf_d, ill_q, ill_d;
  logic [XLEN-1:0] data_q, data_d, pc_q, pc_d, hi_q, hi_d, lo_q, lo_d, md_pc_q, md_pc_d;
  logic [4:0]      waddr_q, waddr_d, md_waddr_q, md_waddr_d;

  assign in_ready_o = ~md_busy & (~ov_q | out_ready_i) & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;
  assign is_md      = op_is_mul(op_i) | op_is_div(op_i);
  assign sum        = a_i + b_i;
  assign diff       = a_i - b_i;
  assign add_ovf    = (a_i[XLEN-1] == b_i[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1]);
  assign sub_ovf    = (a_i[XLEN-1] != b_i[XLEN-1]) && (diff[XLEN-1] != a_i[XLEN-1]);

  fairy_exu_mdu #(.XLEN(XLEN)) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .abort_i  (flush_i),
    .start_i  (accept & is_md),
    .signed_i (op_is_signed_md(op_i)),
    .is_div_i (op_is_div(op_i)),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .hi_o     (md_hi),
    .lo_o     (md_lo)
  );

  // Single-cycle result, exception flags and qualified write enable
  always_comb begin
    res = '0;
    ovf = 1'b0;
    ill = 1'b0;
    wr  = we_i;
    case (op_i)
      OP_ADD:  begin res = sum;  ovf = add_ovf; end
      OP_ADDU: res = sum;
      OP_SUB:  begin res = diff; ovf = sub_ovf; end
      OP_SUBU: res = diff;
      OP_SLT:  res = XLEN'($signed(a_i) < $signed(b_i));
      OP_SLTU: res = XLEN'(a_i < b_i);
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_XOR:  res = a_i ^ b_i;
      OP_NOR:  res = ~(a_i | b_i);
      OP_SLL:  res = b_i << shamt_i;
      OP_SRL:  res = b_i >> shamt_i;
      OP_SRA:  res = $signed(b_i) >>> shamt_i;
      OP_LUI:  res = b_i << 16;
      OP_MFHI: res = hi_q;
      OP_MFLO: res = lo_q;
      OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU: wr = 1'b0;
      OP_DIV, OP_DIVU: begin wr = 1'b0; ill = ~DIV_EN; end
      default: begin wr = 1'b0; ill = 1'b1; end
    endcase
    if (ovf) wr = 1'b0;
  end

  // Next output entry and HI/LO; flush beats MDU completion and new acceptance
  always_comb begin
    ov_d       = ov_q;
    data_d     = data_q;
    pc_d       = pc_q;
    waddr_d    = waddr_q;
    we_d       = we_q;
    ovf_d      = ovf_q;
    ill_d      = ill_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    md_pc_d    = (accept && is_md) ? pc_i : md_pc_q;
    md_waddr_d = (accept && is_md) ? waddr_i : md_waddr_q;
    if (flush_i) begin
      ov_d = 1'b0;
    end else if (md_done) begin
      ov_d    = 1'b1;
      data_d  = '0;
      pc_d    = md_pc_q;
      waddr_d = md_waddr_q;
      we_d    = 1'b0;
      ovf_d   = 1'b0;
      ill_d   = 1'b0;
      hi_d    = md_hi;
      lo_d    = md_lo;
    end else if (accept && !is_md) begin
      ov_d    = 1'b1;
      data_d  = res;
      pc_d    = pc_i;
      waddr_d = waddr_i;
      we_d    = wr;
      ovf_d   = ovf;
      ill_d   = ill;
      if (op_i == OP_MTHI) hi_d = a_i;
      if (op_i == OP_MTLO) lo_d = a_i;
    end else if (out_ready_i) begin
      ov_d = 1'b0;
    end
  end

  // Output entry, HI/LO and multiply/divide tag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ov_q       <= 1'b0;
      data_q     <= '0;
      pc_q       <= '0;
      waddr_q    <= '0;
      we_q       <= 1'b0;
      ovf_q      <= 1'b0;
      ill_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      md_pc_q    <= '0;
      md_waddr_q <= '0;
    end else begin
      ov_q       <= ov_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
      waddr_q    <= waddr_d;
      we_q       <= we_d;
      ovf_q      <= ovf_d;
      ill_q      <= ill_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      md_pc_q    <= md_pc_d;
      md_waddr_q <= md_waddr_d;
    end
  end

  assign out_valid_o = ov_q;
  assign data_o      = data_q;
  assign pc_o        = pc_q;
  assign waddr_o     = waddr_q;
  assign we_o        = we_q;
  assign overflow_o  = ovf_q;
  assign illegal_o   = ill_q;
  assign busy_o      = md_busy;

endmodule

// File: tb/tb_fairy_exe_unit.sv
// tb/tb_fairy_exe_unit.sv - table-driven scoreboard bench for fairy_exe_unit
`timescale 1ns/1ps
module tb_fairy_exe_unit;
  import fairy_exu_pkg::*;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  logic               clk = 1'b0;
  logic               reset, flush_i, in_valid_i, in_ready_o, we_i;
  op_e                op_i;
  logic [XLEN-1:0]    a_i, b_i, pc_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic [4:0]         waddr_i;
  logic               out_valid_o, out_ready_i, we_o, overflow_o, illegal_o, busy_o;
  logic [XLEN-1:0]    data_o, pc_o;
  logic [4:0]         waddr_o;

  always #5 clk = ~clk;

  fairy_exe_unit #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .shamt_i(shamt_i), .pc_i(pc_i), .waddr_i(waddr_i), .we_i(we_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .data_o(data_o), .pc_o(pc_o),
    .waddr_o(waddr_o), .we_o(we_o), .overflow_o(overflow_o), .illegal_o(illegal_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        we, ovf, ill;
    logic [31:0] pc;
    logic [4:0]  waddr;
  } exp_t;

  typedef struct {
    op_e         op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic        we;
    logic [31:0] d;
    logic        ewe, ovf, ill;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vt[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] pc_ctr = 32'h1000;
  logic [31:0] last_pc;
  logic [4:0]  last_waddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every consumed result is compared against the oldest expectation
  always @(negedge clk) begin
    if (!reset && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got data 0x%0h pc 0x%0h, expected no result", data_o, pc_o);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", data_o, mon_e.data);
        chk("out_flags_we_ovf_ill", {we_o, overflow_o, illegal_o}, {mon_e.we, mon_e.ovf, mon_e.ill});
        chk("out_pc", pc_o, mon_e.pc);
        chk("out_waddr", waddr_o, mon_e.waddr);
      end
    end
  end

  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic we);
    int n;
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; shamt_i = sh; we_i = we;
    pc_i = pc_ctr; waddr_i = pc_ctr[6:2]; in_valid_i = 1'b1;
    n = 0;
    #1;
    while (!in_ready_o && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready_o) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: in_ready_o got 0 expected 1");
    end
    last_pc = pc_ctr;
    last_waddr = pc_ctr[6:2];
    pc_ctr = pc_ctr + 32'd4;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic expect_out(input logic [31:0] d, input logic we, input logic ovf, input logic ill);
    sb.push_back('{d, we, ovf, ill, last_pc, last_waddr});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_queue_size", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int          n;
    logic [31:0] ra, rb, rexp;
    op_e         rop;

    reset = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    op_i = OP_ADD; a_i = '0; b_i = '0; shamt_i = '0; pc_i = '0; waddr_i = '0; we_i = 1'b0;

    //             op       a             b             sh  we  data          we  ovf ill
    vt.push_back('{OP_ADD,  32'd5,        32'd7,        5'd0, 1, 32'd12,       1, 0, 0});
    vt.push_back('{OP_ADD,  32'h7FFFFFFF, 32'd1,        5'd0, 1, 32'h80000000, 0, 1, 0});
    vt.push_back('{OP_ADDU, 32'h7FFFFFFF, 32'd1,        5'd0, 1, 32'h80000000, 1, 0, 0});
    vt.push_back('{OP_SUB,  32'h80000000, 32'd1,        5'd0, 1, 32'h7FFFFFFF, 0, 1, 0});
    vt.push_back('{OP_SUBU, 32'd3,        32'd5,        5'd0, 1, 32'hFFFFFFFE, 1, 0, 0});
    vt.push_back('{OP_SLT,  32'hFFFFFFFF, 32'd1,        5'd0, 1, 32'd1,        1, 0, 0});
    vt.push_back('{OP_SLTU, 32'hFFFFFFFF, 32'd1,        5'd0, 1, 32'd0,        1, 0, 0});
    vt.push_back('{OP_AND,  32'hF0F01234, 32'h0FF0FF00, 5'd0, 1, 32'h00F01200, 1, 0, 0});
    vt.push_back('{OP_OR,   32'hF0000000, 32'h0000000F, 5'd0, 0, 32'hF000000F, 0, 0, 0});
    vt.push_back('{OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 5'd0, 1, 32'hF0F00F0F, 1, 0, 0});
    vt.push_back('{OP_NOR,  32'h00000000, 32'h0000FFFF, 5'd0, 1, 32'hFFFF0000, 1, 0, 0});
    vt.push_back('{OP_SLL,  32'hDEAD0000, 32'd1,        5'd31, 1, 32'h80000000, 1, 0, 0});
    vt.push_back('{OP_SRL,  32'hDEAD0000, 32'h80000000, 5'd4, 1, 32'h08000000, 1, 0, 0});
    vt.push_back('{OP_SRA,  32'hDEAD0000, 32'h80000000, 5'd4, 1, 32'hF8000000, 1, 0, 0});
    vt.push_back('{OP_SRA,  32'h0,        32'h7FFFFFF0, 5'd4, 1, 32'h07FFFFFF, 1, 0, 0});
    vt.push_back('{OP_SRA,  32'h0,        32'h80000001, 5'd0, 1, 32'h80000001, 1, 0, 0});
    vt.push_back('{OP_LUI,  32'h0,        32'h0000ABCD, 5'd0, 1, 32'hABCD0000, 1, 0, 0});
    vt.push_back('{op_e'(5'd31), 32'd1,   32'd2,        5'd0, 1, 32'd0,        0, 0, 1});

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_out_valid", out_valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_in_ready", in_ready_o, 1);
    chk("reset_data", data_o, 0);
    chk("reset_flags", {we_o, overflow_o, illegal_o}, 3'b000);

    issue(OP_MFHI, 0, 0, 0, 1); expect_out(32'd0, 1, 0, 0);
    issue(OP_MFLO, 0, 0, 0, 1); expect_out(32'd0, 1, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].sh, vt[i].we);
      expect_out(vt[i].d, vt[i].ewe, vt[i].ovf, vt[i].ill);
    end

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 2))
        0:       begin rop = OP_ADDU; rexp = ra + rb; end
        1:       begin rop = OP_SUBU; rexp = ra - rb; end
        default: begin rop = OP_XOR;  rexp = ra ^ rb; end
      endcase
      issue(rop, ra, rb, 0, 1);
      expect_out(rexp, 1, 0, 0);
    end
    drain();

    issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 0, 1);
    expect_out(32'd0, 0, 0, 0);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == 5) chk("mult_busy", {busy_o, in_ready_o}, 2'b10);
      if (out_valid_o) break;
    end
    chk("mult_latency", n, 34);
    issue(OP_MFHI, 0, 0, 0, 1); expect_out(32'hFFFFFFFF, 1, 0, 0);
    issue(OP_MFLO, 0, 0, 0, 1); expect_out(32'hFFFFFFFA, 1, 0, 0);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1); expect_out(32'd0, 0, 0, 0);
    issue(OP_MFHI, 0, 0, 0, 1); expect_out(32'hFFFFFFFE, 1, 0, 0);
    issue(OP_MFLO, 0, 0, 0, 1); expect_out(32'h00000001, 1, 0, 0);

`ifdef FAIRY_EXU_DIV_EN
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 1); expect_out(32'd0, 0, 0, 0);
    issue(OP_MFLO, 0, 0, 0, 1); expect_out(32'hFFFFFFFD, 1, 0, 0);
    issue(OP_MFHI, 0, 0, 0, 1); expect_out(32'hFFFFFFFF, 1, 0, 0);
    issue(OP_DIVU, 32'd5, 32'd0, 0, 1); expect_out(32'd0, 0, 0, 0);
    issue(OP_MFHI, 0, 0, 0, 1); expect_out(32'd5, 1, 0, 0);
    issue(OP_MFLO, 0, 0, 0, 1); expect_out(32'hFFFFFFFF, 1, 0, 0);
    issue(OP_DIV, 32'd8, 32'd2, 0, 1); expect_out(32'd0, 0, 0, 0);
    issue(OP_MFLO, 0, 0, 0, 1); expect_out(32'd4, 1, 0, 0);
    issue(OP_MFHI, 0, 0, 0, 1); expect_out(32'd0, 1, 0, 0);
`else
    issue(OP_DIV, 32'd8, 32'd2, 0, 1); expect_out(32'd0, 0, 0, 1);
    @(negedge clk);
    chk("div_illegal_latency", {out_valid_o, illegal_o, busy_o}, 3'b110);
    issue(OP_DIVU, 32'd9, 32'd3, 0, 1); expect_out(32'd0, 0, 0, 1);
    issue(OP_MFHI, 0, 0, 0, 1); expect_out(32'hFFFFFFFE, 1, 0, 0);
    issue(OP_MFLO, 0, 0, 0, 1); expect_out(32'h00000001, 1, 0, 0);
`endif
    drain();

    // Held result: consumer stalls three cycles while a second op is offered
    out_ready_i = 1'b0;
    issue(OP_SLT, 32'hFFFFFFFF, 32'd1, 0, 1); expect_out(32'd1, 1, 0, 0);
    op_i = OP_ADD; a_i = 32'd1; b_i = 32'd2; in_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid_o, 1);
      chk("hold_data", data_o, 1);
      chk("hold_in_ready", in_ready_o, 0);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    drain();

    // Flush aborts a running MULTU without touching HI
    issue(OP_MTHI, 32'h1234, 0, 0, 0); expect_out(32'd0, 0, 0, 0);
    issue(OP_MULTU, 32'hFFFF, 32'hFFFF, 0, 1);
    repeat (10) @(negedge clk);
    chk("flush_busy_before", busy_o, 1);
    flush_i = 1'b1;
    #1;
    chk("flush_in_ready", in_ready_o, 0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush_busy_after", busy_o, 0);
    issue(OP_MFHI, 0, 0, 0, 1); expect_out(32'h1234, 1, 0, 0);
    drain();

    // Flush drops a stalled result entry
    out_ready_i = 1'b0;
    issue(OP_ADD, 32'd1, 32'd1, 0, 1);
    @(negedge clk);
    chk("flush_entry_before", out_valid_o, 1);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush_entry_after", out_valid_o, 0);
    out_ready_i = 1'b1;
    issue(OP_ADD, 32'd10, 32'd20, 0, 1); expect_out(32'd30, 1, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
